mem_fill_arbiter: RTL and testbench

//  Sits between the I-cache/D-cache miss paths and the single-ported, pipelined main memory.

---
 rtl/mem_fill_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_arbiter
// Description : Arbitrates the single-ported, pipelined main memory between
//               write-through stores, D-cache block fills and I-cache block
//               fills. Each fill issues BLK_WORDS back-to-back reads and
//               streams the returned words into the requesting cache with a
//               word index, pulsing a done strobe alongside the last word.
// Ports       :
//   clk, rst                      clock (rising edge), async active-low reset
//   icache_miss / icache_addr     I-cache miss request, held until fill_done_i
//   dcache_miss / dcache_addr     D-cache miss request, held until fill_done_d
//   st_req / st_addr / st_data    store request, held until st_ack
//   st_ack                        one-cycle pulse when the store hits memory
//   mem_en/mem_wr/mem_addr/mem_din  memory command (registered)
//   mem_dout / mem_dvalid         memory read return
//   fill_data / fill_word         returned word and its index in the block
//   fill_we_i / fill_we_d         data-array write strobes
//   fill_done_i / fill_done_d     last-word strobes (tag/valid write)
//   busy                          arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fill_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8,
    parameter int MEM_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         icache_miss,
    input  logic [ADDR_W-1:0]            icache_addr,
    input  logic                         dcache_miss,
    input  logic [ADDR_W-1:0]            dcache_addr,
    input  logic                         st_req,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ack,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_din,
    input  logic [DATA_W-1:0]            mem_dout,
    input  logic                         mem_dvalid,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         fill_we_i,
    output logic                         fill_we_d,
    output logic                         fill_done_i,
    output logic                         fill_done_d,
    output logic                         busy
);

    localparam int c_word_w = $clog2(BLK_WORDS);
    localparam int c_cnt_w  = c_word_w + 1;
    // Byte-offset bits of a block (block = 2*BLK_WORDS bytes).
    localparam logic [ADDR_W-1:0] c_off_mask = ADDR_W'(2 * BLK_WORDS - 1);
    localparam logic [c_cnt_w-1:0] c_blk_words = c_cnt_w'(BLK_WORDS);
    localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(BLK_WORDS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_bad_blk
            $error("BLK_WORDS must be a power of two >= 2");
        end
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("MEM_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STORE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_issue_cnt;
    logic [c_cnt_w-1:0]   r_ret_cnt;
    logic [ADDR_W-1:0]    r_base;

    logic                 w_in_fill;
    logic                 w_last;
    logic                 w_issue_more;
    logic [ADDR_W-1:0]    w_miss_blk;
    logic [ADDR_W-1:0]    w_next_addr;

    assign w_in_fill    = (r_state == FILL_I) || (r_state == FILL_D);
    assign w_last       = (r_ret_cnt == c_last_word);
    assign w_issue_more = (r_issue_cnt < c_blk_words);
    // D-miss wins over I-miss, so the block address follows the same choice.
    assign w_miss_blk   = (dcache_miss ? dcache_addr : icache_addr) & ~c_off_mask;
    assign w_next_addr  = r_base + ADDR_W'({r_issue_cnt, 1'b0});

    // Return path is combinational: a word is written the same cycle the
    // memory presents it. Returns outside a fill (e.g. reads left in flight
    // by a reset) are dropped here.
    assign fill_we_i   = (r_state == FILL_I) && mem_dvalid;
    assign fill_we_d   = (r_state == FILL_D) && mem_dvalid;
    assign fill_done_i = fill_we_i && w_last;
    assign fill_done_d = fill_we_d && w_last;
    assign fill_word   = r_ret_cnt[c_word_w-1:0];
    assign fill_data   = w_in_fill ? mem_dout : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_base      <= '0;
            st_ack      <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            busy        <= 1'b0;
        end else begin
            // Memory command is a one-cycle registered strobe by default.
            st_ack   <= 1'b0;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;

            case (r_state)
                IDLE: begin
                    if (st_req) begin
                        r_state  <= STORE;
                        busy     <= 1'b1;
                        st_ack   <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_wr   <= 1'b1;
                        mem_addr <= st_addr;
                        mem_din  <= st_data;
                    end else if (dcache_miss || icache_miss) begin
                        r_state     <= dcache_miss ? FILL_D : FILL_I;
                        busy        <= 1'b1;
                        r_base      <= w_miss_blk;
                        r_ret_cnt   <= '0;
                        // The first read leaves with the grant, so the issue
                        // counter already accounts for it on fill entry.
                        mem_en      <= 1'b1;
                        mem_addr    <= w_miss_blk;
                        r_issue_cnt <= c_cnt_one;
                    end
                end

                STORE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end

                FILL_I, FILL_D: begin
                    if (w_issue_more) begin
                        mem_en      <= 1'b1;
                        mem_addr    <= w_next_addr;
                        r_issue_cnt <= r_issue_cnt + c_cnt_one;
                    end
                    // Completion is driven purely by returns, so a dropped
                    // request still drains every read already in flight.
                    if (mem_dvalid) begin
                        if (w_last) begin
                            r_state     <= IDLE;
                            busy        <= 1'b0;
                            r_ret_cnt   <= '0;
                            r_issue_cnt <= '0;
                        end else begin
                            r_ret_cnt <= r_ret_cnt + c_cnt_one;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fill_arbiter
// Description : Scoreboard bench for mem_fill_arbiter. A reference model
//               schedules service in request-priority order and predicts the
//               memory commands and fill words with their cycle stamps; a
//               monitor compares every DUT memory command and fill strobe
//               against those predictions. Includes a pipelined memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fill_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int BLK_WORDS = 8;
    localparam int MEM_LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_miss = 1'b0, dcache_miss = 1'b0, st_req = 1'b0;
    logic [15:0] icache_addr = '0, dcache_addr = '0, st_addr = '0, st_data = '0;
    logic        st_ack, mem_en, mem_wr, mem_dvalid;
    logic [15:0] mem_addr, mem_din, mem_dout, fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i, fill_we_d, fill_done_i, fill_done_d, busy;
    logic        inject_dv = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_fill_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_dvalid(mem_dvalid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .fill_done_i(fill_done_i), .fill_done_d(fill_done_d), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- memory model: fixed-latency read pipeline -------------
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    logic        pv [MEM_LAT] = '{default: 1'b0};
    logic [15:0] pa [MEM_LAT] = '{default: 16'h0};

    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_wr;
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign mem_dvalid = pv[MEM_LAT-1] | inject_dv;
    assign mem_dout   = inject_dv ? 16'hDEAD : mem_fn(pa[MEM_LAT-1]);

    // ---------------- scoreboard -------------------------------------------
    typedef struct { int stamp; bit wr; logic [15:0] addr; logic [15:0] data; } mem_t;
    typedef struct { int stamp; bit is_d; logic [2:0] word; logic [15:0] data; bit done; } fill_t;

    mem_t  mq[$];
    fill_t fq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, granted by priority
    // store > D-miss > I-miss whenever the previous one has finished.
    // Event stamps name the clock edge at which the event is sampled.
    int free_at = 0;
    int g_t     = 0;

    task automatic plan_fill(input int t, input bit is_d, input logic [15:0] a);
        mem_t  m;
        fill_t f;
        logic [15:0] b;
        b = (a / 16'd16) * 16'd16;
        for (int i = 0; i < BLK_WORDS; i++) begin
            m = '{t + 1 + i, 1'b0, b + 16'(2 * i), 16'h0};
            mq.push_back(m);
            f = '{t + 1 + i + MEM_LAT, is_d, 3'(i), mem_fn(b + 16'(2 * i)), (i == BLK_WORDS - 1)};
            fq.push_back(f);
        end
        g_t     = t;
        free_at = t + BLK_WORDS + MEM_LAT + 1;
    endtask

    always @(negedge clk) begin
        int   t;
        mem_t m;
        if (!rst) begin
            mq.delete();
            fq.delete();
            free_at = 0;
            g_t     = 0;
        end else begin
            chk("busy", busy, (cyc >= g_t && cyc < free_at - 1));
            if (cyc + 1 >= free_at) begin
                t = cyc + 1;
                if (st_req) begin
                    m = '{t + 1, 1'b1, st_addr, st_data};
                    mq.push_back(m);
                    g_t     = t;
                    free_at = t + 2;
                end else if (dcache_miss) begin
                    plan_fill(t, 1'b1, dcache_addr);
                end else if (icache_miss) begin
                    plan_fill(t, 1'b0, icache_addr);
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the queued predictions.
    always @(negedge clk) begin
        int    now;
        mem_t  m;
        fill_t f;
        if (!rst) begin
            chk("reset_outputs", {mem_en, mem_wr, mem_addr, mem_din, st_ack, fill_we_i, fill_we_d,
                                  fill_done_i, fill_done_d, fill_word, fill_data, busy}, 64'd0);
        end else begin
            now = cyc + 1;
            while (mq.size() > 0 && mq[0].stamp < now) begin
                m = mq.pop_front();
                chk("mem_missing", now, m.stamp);
            end
            while (fq.size() > 0 && fq[0].stamp < now) begin
                f = fq.pop_front();
                chk("fill_missing", now, f.stamp);
            end
            if (mem_en) begin
                if (mq.size() == 0) begin
                    chk("mem_unexpected", mem_en, 0);
                end else begin
                    m = mq.pop_front();
                    chk("mem_time", now, m.stamp);
                    chk("mem_cmd", {mem_wr, mem_addr, (m.wr ? mem_din : 16'h0), st_ack},
                                   {m.wr, m.addr, (m.wr ? m.data : 16'h0), m.wr});
                end
            end else if (st_ack) begin
                chk("st_ack_stray", st_ack, 0);
            end
            if (fill_we_i || fill_we_d) begin
                chk("fill_exclusive", fill_we_i & fill_we_d, 0);
                if (fq.size() == 0) begin
                    chk("fill_unexpected", {fill_we_i, fill_we_d}, 0);
                end else begin
                    f = fq.pop_front();
                    chk("fill_time", now, f.stamp);
                    chk("fill_word", {fill_we_d, fill_we_i, fill_word, fill_data, fill_done_i, fill_done_d},
                                     {f.is_d, !f.is_d, f.word, f.data, f.done && !f.is_d, f.done && f.is_d});
                end
            end else if (fill_done_i || fill_done_d) begin
                chk("done_stray", {fill_done_i, fill_done_d}, 0);
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic wait_fill(input bit is_d);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (is_d ? fill_done_d : fill_done_i) return;
        end
        chk(is_d ? "fill_done_d_timeout" : "fill_done_i_timeout", is_d ? fill_done_d : fill_done_i, 1);
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) return;
        end
        chk("busy_timeout", busy, 1);
    endtask

    task automatic do_miss(input bit is_d, input logic [15:0] a);
        @(posedge clk); #1;
        if (is_d) begin dcache_addr = a; dcache_miss = 1'b1; end
        else      begin icache_addr = a; icache_miss = 1'b1; end
        wait_fill(is_d);
        @(posedge clk); #1;
        if (is_d) dcache_miss = 1'b0;
        else      icache_miss = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        bit got;
        @(posedge clk); #1;
        st_addr = a; st_data = d; st_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 800 && !got; k++) begin
            @(negedge clk);
            got = st_ack;
        end
        if (!got) chk("st_ack_timeout", st_ack, 1);
        @(posedge clk); #1;
        st_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single I-miss, mid-block address.
        do_miss(1'b0, 16'h0046);

        // Store, D-miss and I-miss raised together.
        fork
            do_store(16'h1002, 16'hBEEF);
            do_miss(1'b1, 16'h0522);
            do_miss(1'b0, 16'h0734);
        join

        // Store arriving while a D fill is in progress.
        fork
            do_miss(1'b1, 16'h0A10);
            begin
                wait_busy();
                repeat (2) @(posedge clk);
                do_store(16'h0A20, 16'h1234);
            end
        join

        // Reset in the middle of a D fill, then stray returns, then refill.
        @(posedge clk); #1;
        dcache_addr = 16'h2234; dcache_miss = 1'b1;
        wait_busy();
        repeat (6) @(posedge clk);
        #2 rst = 1'b0; dcache_miss = 1'b0;
        #1 chk("async_reset", {mem_en, busy, fill_we_d, mem_addr}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 inject_dv = 1'b1;
        @(posedge clk); #1 inject_dv = 1'b0;
        repeat (8) @(posedge clk);
        do_miss(1'b1, 16'h2238);

        // Top-of-memory block.
        do_miss(1'b1, 16'hFFF2);

        // I-miss dropped shortly after grant: fill must still complete once.
        @(posedge clk); #1;
        icache_addr = 16'h0310; icache_miss = 1'b1;
        wait_busy();
        repeat (2) @(posedge clk);
        #1 icache_miss = 1'b0;
        wait_fill(1'b0);
        repeat (4) @(posedge clk);

        // Randomised concurrent traffic from all three requesters.
        fork
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                do_miss(1'b0, 16'($urandom));
            end
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                do_miss(1'b1, 16'($urandom));
            end
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                do_store(16'($urandom), 16'($urandom));
            end
        join

        repeat (30) @(posedge clk);
        chk("scoreboard_drained", {16'(mq.size()), 16'(fq.size())}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
